// File: rtl/sprite_overlay.sv
// Sprite compositor: overlays up to MAX_PER_LINE 16x16 sprites on the background pixel stream.
// rgb is registered 1 clk after a pix_en edge; no backpressure, per-line evaluation must fit in hblank.
module sprite_overlay #(
    parameter int NUM_SPRITES  = 8,
    parameter int MAX_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    input  logic        pix_en,
    input  logic        line_start,
    input  logic [9:0]  x_px,
    input  logic [9:0]  y_px,
    input  logic        active,
    input  logic [2:0]  bg_rgb,
    output logic        spr_tex_ren,
    output logic [11:0] spr_tex_raddr,
    input  logic [2:0]  spr_tex_rdata,
    output logic [2:0]  rgb,
    output logic        spr_overflow,
    output logic        busy
);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int SW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int CW = $clog2(MAX_PER_LINE + 1);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, SWAP} state_t;
    state_t state_q, state_d;

    logic [9:0]             ax_q   [NUM_SPRITES];
    logic [9:0]             ay_q   [NUM_SPRITES];
    logic [5:0]             atex_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] aen_q;

    logic [9:0]    bx_q    [MAX_PER_LINE];
    logic [5:0]    btex_q  [MAX_PER_LINE];
    logic [2:0]    brow_q  [MAX_PER_LINE];
    logic [23:0]   bbits_q [MAX_PER_LINE];
    logic [9:0]    dx_q    [MAX_PER_LINE];
    logic [23:0]   dbits_q [MAX_PER_LINE];

    logic [9:0]    line_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] bcnt_q, dcnt_q;
    logic          bovf_q, ovf_q;
    logic [SW-1:0] fslot_q;
    logic [2:0]    fcol_q;
    logic          fph_q;
    logic [2:0]    rgb_q;

    logic wr_en, unused_bits;
    assign wr_en = iomem_valid && (iomem_wstrb == 4'hF) && (iomem_addr[23:20] == 4'h3);
    assign unused_bits = ^{iomem_addr[31:24], iomem_addr[19:2+IW], iomem_addr[1:0], iomem_wdata[30:26]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) aen_q <= '0;
        else if (wr_en) aen_q[iomem_addr[2 +: IW]] <= iomem_wdata[31];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ax_q[iomem_addr[2 +: IW]]   <= iomem_wdata[9:0];
            ay_q[iomem_addr[2 +: IW]]   <= iomem_wdata[19:10];
            atex_q[iomem_addr[2 +: IW]] <= iomem_wdata[25:20];
        end
    end

    // Scanner compares the target line against one attribute entry per clk.
    logic [9:0] scan_dy;
    logic       scan_vis, scan_last, slots_full, fetch_last;
    assign scan_dy    = line_q - ay_q[idx_q];
    assign scan_vis   = aen_q[idx_q] && (scan_dy < 10'd16);
    assign scan_last  = (idx_q == IW'(NUM_SPRITES - 1));
    assign slots_full = (bcnt_q == CW'(MAX_PER_LINE));
    assign fetch_last = (fslot_q == SW'(bcnt_q - 1'b1)) && (fcol_q == 3'd7) && fph_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        busy          = (state_q == SCAN) || (state_q == FETCH);
        spr_tex_ren   = (state_q == FETCH) && !fph_q;
        spr_tex_raddr = '0;
        if (spr_tex_ren) spr_tex_raddr = {btex_q[fslot_q], brow_q[fslot_q], fcol_q};
        if (line_start) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                SCAN:  if (scan_last)
                           state_d = ((bcnt_q != '0) || (scan_vis && !slots_full)) ? FETCH : SWAP;
                FETCH: if (fetch_last) state_d = SWAP;
                SWAP:  state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            bovf_q  <= 1'b0;
            fslot_q <= '0;
            fcol_q  <= '0;
            fph_q   <= 1'b0;
            dcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (line_start) begin
            line_q  <= y_px + 10'd1;
            idx_q   <= '0;
            bcnt_q  <= '0;
            bovf_q  <= 1'b0;
            fslot_q <= '0;
            fcol_q  <= '0;
            fph_q   <= 1'b0;
            // A restart mid-evaluation leaves no coherent set; blank the next line instead.
            if (state_q != IDLE) dcnt_q <= '0;
        end else begin
            case (state_q)
                SCAN: begin
                    idx_q <= idx_q + 1'b1;
                    if (scan_vis) begin
                        if (slots_full) bovf_q <= 1'b1;
                        else            bcnt_q <= bcnt_q + 1'b1;
                    end
                end
                FETCH: begin
                    fph_q <= !fph_q;
                    if (fph_q) begin
                        fcol_q <= fcol_q + 1'b1;
                        if (fcol_q == 3'd7) fslot_q <= fslot_q + 1'b1;
                    end
                end
                SWAP: begin
                    dcnt_q <= bcnt_q;
                    ovf_q  <= bovf_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!line_start && (state_q == SCAN) && scan_vis && !slots_full) begin
            bx_q[bcnt_q[SW-1:0]]   <= ax_q[idx_q];
            btex_q[bcnt_q[SW-1:0]] <= atex_q[idx_q];
            brow_q[bcnt_q[SW-1:0]] <= scan_dy[3:1];
        end
        if (!line_start && (state_q == FETCH) && fph_q)
            bbits_q[fslot_q][3*fcol_q +: 3] <= spr_tex_rdata;
        if (!line_start && (state_q == SWAP)) begin
            dx_q    <= bx_q;
            dbits_q <= bbits_q;
        end
    end

    // Lowest-numbered slot with an opaque texel under this pixel wins.
    logic [9:0] pdx;
    logic [2:0] ptx, hit_tx, rgb_d;
    logic       hit;
    always_comb begin
        pdx    = '0;
        ptx    = '0;
        hit    = 1'b0;
        hit_tx = 3'b000;
        for (int s = 0; s < MAX_PER_LINE; s++) begin
            pdx = x_px - dx_q[s];
            ptx = dbits_q[s][3*pdx[3:1] +: 3];
            if (!hit && (s < int'(dcnt_q)) && (pdx < 10'd16) && (ptx != 3'b000)) begin
                hit    = 1'b1;
                hit_tx = ptx;
            end
        end
        rgb_d = !active ? 3'b000 : (hit ? hit_tx : bg_rgb);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     rgb_q <= '0;
        else if (pix_en) rgb_q <= rgb_d;
    end

    assign rgb          = rgb_q;
    assign spr_overflow = ovf_q;
endmodule

// File: tb/tb_sprite_overlay.sv
// Directed and randomized checks of sprite_overlay against a line-level reference model.
module tb_sprite_overlay;
    localparam int NS = 8;
    localparam int MP = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic        pix_en = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  x_px = '0;
    logic [9:0]  y_px = '0;
    logic        active = 1'b0;
    logic [2:0]  bg_rgb = '0;
    logic        spr_tex_ren;
    logic [11:0] spr_tex_raddr;
    logic [2:0]  spr_tex_rdata = '0;
    logic [2:0]  rgb;
    logic        spr_overflow;
    logic        busy;

    sprite_overlay #(.NUM_SPRITES(NS), .MAX_PER_LINE(MP)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .pix_en(pix_en), .line_start(line_start),
        .x_px(x_px), .y_px(y_px), .active(active), .bg_rgb(bg_rgb),
        .spr_tex_ren(spr_tex_ren), .spr_tex_raddr(spr_tex_raddr),
        .spr_tex_rdata(spr_tex_rdata),
        .rgb(rgb), .spr_overflow(spr_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [2:0]  tex_mem [0:4095];
    logic [11:0] rd_q [$];
    always @(posedge clk) begin
        if (spr_tex_ren) begin
            spr_tex_rdata <= tex_mem[spr_tex_raddr];
            rd_q.push_back(spr_tex_raddr);
        end
    end

    int m_x [NS];
    int m_y [NS];
    int m_tex [NS];
    int m_en [NS];
    int d_list [$];
    int d_L;
    int m_ovf;
    int vectors = 0;
    int miscompares = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input int x, input int y, input int tex, input int en,
                      input logic [3:0] strb);
        iomem_valid = 1'b1;
        iomem_wstrb = strb;
        iomem_addr  = 32'h0530_0000 | (idx << 2);
        iomem_wdata = {en[0], 5'b0, tex[5:0], y[9:0], x[9:0]};
        tick();
        iomem_valid = 1'b0;
        if (strb == 4'hF) begin
            m_x[idx] = x & 1023; m_y[idx] = y & 1023; m_tex[idx] = tex & 63; m_en[idx] = en & 1;
        end
    endtask

    task automatic model_commit(input int L);
        d_list.delete();
        m_ovf = 0;
        d_L = L & 1023;
        for (int k = 0; k < NS; k++)
            if (m_en[k] != 0 && ((d_L - m_y[k]) & 1023) < 16) begin
                if (d_list.size() < MP) d_list.push_back(k);
                else m_ovf = 1;
            end
    endtask

    function automatic int exp_rgb(input int x, input int bg, input int act);
        int k, dx, row, t;
        if (act == 0) return 0;
        foreach (d_list[i]) begin
            k  = d_list[i];
            dx = (x - m_x[k]) & 1023;
            if (dx < 16) begin
                row = ((d_L - m_y[k]) & 1023) / 2;
                t   = tex_mem[m_tex[k] * 64 + row * 8 + dx / 2];
                if (t != 0) return t;
            end
        end
        return bg;
    endfunction

    task automatic pix(input int x, input int L, input int act);
        int bg;
        bg = $urandom_range(0, 7);
        x_px = x[9:0]; y_px = L[9:0]; active = act[0]; bg_rgb = bg[2:0];
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        check("pixel", {29'd0, rgb}, exp_rgb(x, bg, act));
    endtask

    task automatic run_line(input int L);
        int cyc;
        y_px = 10'(L - 1);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
        tick();
        check("eval_within_73", {31'd0, (cyc + 1 <= 73)}, 1);
        model_commit(L);
    endtask

    task automatic fill_tex(input int t, input int v);
        for (int i = 0; i < 64; i++) tex_mem[t * 64 + i] = v[2:0];
    endtask

    initial begin
        int xs [8];
        int n;
        for (int i = 0; i < 4096; i++) tex_mem[i] = 3'($urandom);
        for (int k = 0; k < NS; k++) begin m_x[k] = 0; m_y[k] = 0; m_tex[k] = 0; m_en[k] = 0; end
        d_L = 0; m_ovf = 0;

        // reset state
        #23;
        check("reset_rgb", {29'd0, rgb}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_ren", {31'd0, spr_tex_ren}, 0);
        check("reset_raddr", {20'd0, spr_tex_raddr}, 0);
        check("reset_ovf", {31'd0, spr_overflow}, 0);
        resetn = 1'b1;
        tick();

        // single sprite, fetch addresses and horizontal edges
        fill_tex(5, 4);
        wr(0, 100, 50, 5, 1, 4'hF);
        rd_q.delete();
        run_line(50);
        check("fetch_count", rd_q.size(), 8);
        for (int c = 0; c < 8; c++)
            if (c < rd_q.size()) check("fetch_addr", {20'd0, rd_q[c]}, {20'd0, 6'd5, 3'd0, 3'(c)});
        pix(100, 50, 1);
        check("spr0_colour", {29'd0, rgb}, 4);
        for (int x = 99; x <= 116; x++) pix(x, 50, 1);
        pix(105, 50, 0);

        // overlap with transparency in sprite 0 column 0
        fill_tex(6, 1);
        tex_mem[6 * 64 + 0] = 3'b000;
        fill_tex(7, 2);
        wr(0, 200, 80, 6, 1, 4'hF);
        wr(1, 200, 80, 7, 1, 4'hF);
        run_line(80);
        pix(200, 80, 1);
        check("overlap_col0", {29'd0, rgb}, 2);
        pix(203, 80, 1);
        check("overlap_col1", {29'd0, rgb}, 1);
        for (int x = 198; x <= 217; x++) pix(x, 80, 1);

        // six sprites on one line: first four shown, overflow flagged
        for (int k = 0; k < 6; k++) begin
            fill_tex(8 + k, k + 1);
            wr(k, 300 + 20 * k, 400, 8 + k, 1, 4'hF);
        end
        run_line(405);
        check("overflow_set", {31'd0, spr_overflow}, 1);
        check("overflow_model", {31'd0, spr_overflow}, m_ovf);
        for (int k = 0; k < 6; k++) pix(303 + 20 * k, 405, 1);
        for (int k = 1; k < 6; k++) wr(k, 0, 0, 0, 0, 4'hF);
        run_line(406);
        check("overflow_clear", {31'd0, spr_overflow}, 0);
        pix(305, 406, 1);

        // wrap at x/y 1020 and ignored partial write
        for (int k = 0; k < NS; k++) wr(k, 0, 0, 0, 0, 4'hF);
        wr(0, 1020, 1020, 14, 1, 4'hF);
        xs = '{1018, 1019, 1020, 1023, 0, 1, 11, 12};
        foreach (xs[j]) if (j == 0) begin end
        for (int l = 0; l < 4; l++) begin
            n = (l == 0) ? 0 : (l == 1) ? 5 : (l == 2) ? 11 : 12;
            run_line(n);
            for (int j = 0; j < 8; j++) pix(xs[j], n, 1);
        end
        wr(0, 500, 500, 1, 1, 4'h1);
        run_line(3);
        pix(0, 3, 1);
        pix(4, 3, 1);
        pix(500, 3, 1);

        // restart while busy
        for (int k = 0; k < 4; k++) wr(k, 100 + 20 * k, 600, 5, 1, 4'hF);
        y_px = 10'd599; line_start = 1'b1; tick(); line_start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check("busy_mid_eval", {31'd0, busy}, 1);
        y_px = 10'd600; line_start = 1'b1; tick(); line_start = 1'b0;
        d_list.delete();
        check("busy_after_restart", {31'd0, busy}, 1);
        pix(105, 601, 1);
        n = 1;
        while (busy && n < 200) begin tick(); n++; end
        tick();
        check("restart_within_73", {31'd0, (n + 1 <= 73)}, 1);
        model_commit(601);
        for (int k = 0; k < 4; k++) pix(105 + 20 * k, 601, 1);

        // asynchronous reset during FETCH
        pix(100, 601, 1);
        y_px = 10'd600; line_start = 1'b1; tick(); line_start = 1'b0;
        n = 0;
        while (!spr_tex_ren && n < 50) begin tick(); n++; end
        check("reached_fetch", {31'd0, spr_tex_ren}, 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_rgb", {29'd0, rgb}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_ren", {31'd0, spr_tex_ren}, 0);
        #10 resetn = 1'b1;
        tick();
        for (int k = 0; k < NS; k++) m_en[k] = 0;
        d_list.delete();
        pix(100, 601, 1);
        run_line(601);
        check("post_reset_ovf", {31'd0, spr_overflow}, 0);
        pix(100, 601, 1);
        pix(165, 601, 1);

        // randomized lines
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 1023);
            for (int k = 0; k < NS; k++)
                wr(k, $urandom_range(0, 1023), n - $urandom_range(0, 24), $urandom_range(0, 63),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0) ? 4'h7 : 4'hF);
            run_line(n);
            check("rand_ovf", {31'd0, spr_overflow}, m_ovf);
            for (int j = 0; j < 12; j++) begin
                if (j < 8 && d_list.size() > 0)
                    pix(m_x[d_list[$urandom_range(0, d_list.size() - 1)]] + $urandom_range(0, 17) - 1,
                        n, ($urandom_range(0, 7) != 0));
                else
                    pix($urandom_range(0, 1023), n, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
